issue_ctrl: RTL and testbench
=============================

// Module: issue_ctrl
// PURPOSE
//  Issue stage between the decoder and the execute unit. Holds one decoded op in an output
//  register and tracks pending GPR writes in a per-register busy scoreboard. Stalls decode on
//  RAW/WAW hazards and releases busy bits on writeback. Decode->execute becomes a registered
//  valid/ready stage with hazard interlock.
// PARAMETERS
//  NREG      32   number of GPRs; x0 is never tracked
//  RS_W      5    register index width, clog2(NREG)
//  PAYLOAD_W 128  width of opaque decoded bundle (opinfo/alu/branch/load/store/sys/imm/mask)
//  CNT_W     16   width of saturating stall-cycle counter
// PORTS
//  clk          in   1          clock, rising edge
//  rst_n        in   1          asynchronous active-low reset
//  d_valid_i    in   1          decoder has a valid op
//  d_ready_o    out  1          op accepted this cycle (combinational)
//  rs1_i        in   RS_W       source 1 index
//  rs2_i        in   RS_W       source 2 index
//  use_rs1_i    in   1          op reads rs1
//  use_rs2_i    in   1          op reads rs2
//  rd_i         in   RS_W       destination index
//  wenReg_i     in   1          op writes rd
//  payload_i    in   PAYLOAD_W  decoded bundle, passed through untouched
//  e_valid_o    out  1          issue slot holds an op
//  e_ready_i    in   1          execute consumes slot this cycle
//  rd_o         out  RS_W       rd of slot op
//  wenReg_o     out  1          wenReg of slot op
//  payload_o    out  PAYLOAD_W  payload of slot op
//  wb_valid_i   in   1          writeback retires a register write
//  wb_rd_i      in   RS_W       register being written back
//  flush_i      in   1          discard slot op (branch redirect)
//  busy_o       out  NREG       scoreboard; bit0 tied 0
//  stall_cnt_o  out  CNT_W      cycles lost to hazards, saturating
// BEHAVIOUR
//  - Reset (async, rst_n=0): e_valid_o=0, rd_o=0, wenReg_o=0, payload_o=0, busy_o=0,
//    stall_cnt_o=0. Reset mid-operation drops the slot op and all busy bits immediately.
//  - Slot FSM: EMPTY (e_valid_o=0) / FULL (e_valid_o=1).
//    EMPTY->FULL on accept. FULL->EMPTY on e_ready_i without accept.
//    FULL->FULL on e_ready_i with accept: back-to-back, no bubble.
//    FULL holds while e_ready_i=0. Outputs stay stable until consumed.
//  - hazard = (use_rs1_i & rs1_i!=0 & busy[rs1_i]) | (use_rs2_i & rs2_i!=0 & busy[rs2_i])
//    | (wenReg_i & rd_i!=0 & busy[rd_i]).
//    Uses the registered busy value: no same-cycle writeback bypass, so one bubble minimum.
//  - d_ready_o = d_valid_i & ~hazard & ~flush_i & (~e_valid_o | e_ready_i). accept = d_ready_o.
//  - On accept: slot <= {rd_i, wenReg_i, payload_i}; if wenReg_i & rd_i!=0, busy[rd_i] <= 1.
//  - On wb_valid_i & wb_rd_i!=0: busy[wb_rd_i] <= 0.
//    Same cycle, same index as an accept set: the set wins (new producer).
//  - flush_i has priority over accept and over e_ready_i. It sets e_valid_o<=0.
//    If the slot was FULL with wenReg_o & rd_o!=0, it also clears busy[rd_o].
//    It does not clear busy bits of ops already consumed by execute.
//  - Writes to x0 never set busy. busy_o[0] is constant 0.
//  - stall_cnt_o increments when d_valid_i & hazard & ~flush_i, and saturates at all-ones.
//  - Latency: accepted op is visible on e_valid_o the next cycle.
//    Throughput is 1 op/cycle absent hazards.
// TESTING
//  1. Reset, then independent ops x1<-, x2<- with e_ready_i=1.
//     -> issued on consecutive cycles; busy_o=0x6.
//  2. op writes x5; next op reads rs1=x5; wb of x5 3 cycles later.
//     -> d_ready_o=0 for 3 cycles; accepted the cycle after wb; stall_cnt_o=3.
//  3. Slot FULL and e_ready_i=0 for 4 cycles.
//     -> e_valid_o, payload_o stable; d_ready_o=0; then e_ready_i=1 & new op -> replaced, no bubble.
//  4. In one cycle: wb_rd_i=x7, accept of op writing x7. -> busy[7]=1 afterwards.
//  5. flush_i with FULL slot (rd=x9, busy[9]=1) and d_valid_i=1.
//     -> e_valid_o=0, busy[9]=0, d_ready_o=0 that cycle.
//  6. op with rd=x0 and wenReg_i=1, then op reading x0. -> busy_o=0, no stall.
//     Also check CNT_W=2 saturates at 3 after 5 stall cycles.

Source files
------------

// File: rtl/issue_ctrl.sv
// Issue stage: one-entry output slot between decode and execute,
// with a per-GPR busy scoreboard that interlocks RAW/WAW hazards.
module issue_ctrl #(
    parameter int NREG      = 32,
    parameter int RS_W      = 5,
    parameter int PAYLOAD_W = 128,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 d_valid_i,
    output logic                 d_ready_o,
    input  logic [RS_W-1:0]      rs1_i,
    input  logic [RS_W-1:0]      rs2_i,
    input  logic                 use_rs1_i,
    input  logic                 use_rs2_i,
    input  logic [RS_W-1:0]      rd_i,
    input  logic                 wenReg_i,
    input  logic [PAYLOAD_W-1:0] payload_i,
    output logic                 e_valid_o,
    input  logic                 e_ready_i,
    output logic [RS_W-1:0]      rd_o,
    output logic                 wenReg_o,
    output logic [PAYLOAD_W-1:0] payload_o,
    input  logic                 wb_valid_i,
    input  logic [RS_W-1:0]      wb_rd_i,
    input  logic                 flush_i,
    output logic [NREG-1:0]      busy_o,
    output logic [CNT_W-1:0]     stall_cnt_o
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_n;
    logic            hazard;
    logic            accept;

    // Registered busy only: a writeback frees its register the next cycle.
    assign hazard = (use_rs1_i && rs1_i != '0 && busy_q[rs1_i])
                  | (use_rs2_i && rs2_i != '0 && busy_q[rs2_i])
                  | (wenReg_i  && rd_i  != '0 && busy_q[rd_i]);

    assign d_ready_o = d_valid_i && !hazard && !flush_i
                    && (!e_valid_o || e_ready_i);
    assign accept    = d_ready_o;
    assign busy_o    = busy_q;

    // Clears first, then the set, so a new producer beats a same-index writeback.
    always_comb begin
        busy_n = busy_q;
        if (flush_i && state == FULL && wenReg_o && rd_o != '0)
            busy_n[rd_o] = 1'b0;
        if (wb_valid_i && wb_rd_i != '0)
            busy_n[wb_rd_i] = 1'b0;
        if (accept && wenReg_i && rd_i != '0)
            busy_n[rd_i] = 1'b1;
        busy_n[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            e_valid_o <= 1'b0;
            rd_o      <= '0;
            wenReg_o  <= 1'b0;
            payload_o <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state     <= FULL;
                        e_valid_o <= 1'b1;
                    end
                end
                FULL: begin
                    if (flush_i) begin
                        state     <= EMPTY;
                        e_valid_o <= 1'b0;
                    end else if (e_ready_i && !accept) begin
                        state     <= EMPTY;
                        e_valid_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    e_valid_o <= 1'b0;
                end
            endcase
            if (accept) begin
                rd_o      <= rd_i;
                wenReg_o  <= wenReg_i;
                payload_o <= payload_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_q <= '0;
        else
            busy_q <= busy_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_o <= '0;
        else if (d_valid_i && hazard && !flush_i && stall_cnt_o != '1)
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Testbench for issue_ctrl: directed scenarios plus a randomized run
// against a scoreboard model of the slot and register busy set.
module tb_issue_ctrl;

    localparam int NREG = 32;
    localparam int RS_W = 5;
    localparam int PW   = 128;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            d_valid, use_rs1, use_rs2, wen, e_ready, wb_valid, flush;
    logic [RS_W-1:0] rs1, rs2, rd, wb_rd;
    logic [PW-1:0]   payload;

    logic            d_ready, e_valid, wen_o;
    logic [RS_W-1:0] rd_o;
    logic [PW-1:0]   payload_o;
    logic [NREG-1:0] busy;
    logic [15:0]     stall;

    logic            d_ready2, e_valid2, wen_o2;
    logic [RS_W-1:0] rd_o2;
    logic [PW-1:0]   payload_o2;
    logic [NREG-1:0] busy2;
    logic [1:0]      stall2;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic [NREG-1:0] m_busy;
    bit              m_valid;
    logic [RS_W-1:0] m_rd;
    bit              m_wen;
    logic [PW-1:0]   m_pay;
    int              m_cnt;

    always #5 clk = ~clk;

    issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .d_valid_i(d_valid), .d_ready_o(d_ready),
        .rs1_i(rs1), .rs2_i(rs2), .use_rs1_i(use_rs1), .use_rs2_i(use_rs2),
        .rd_i(rd), .wenReg_i(wen), .payload_i(payload),
        .e_valid_o(e_valid), .e_ready_i(e_ready),
        .rd_o(rd_o), .wenReg_o(wen_o), .payload_o(payload_o),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .flush_i(flush),
        .busy_o(busy), .stall_cnt_o(stall)
    );

    issue_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .d_valid_i(d_valid), .d_ready_o(d_ready2),
        .rs1_i(rs1), .rs2_i(rs2), .use_rs1_i(use_rs1), .use_rs2_i(use_rs2),
        .rd_i(rd), .wenReg_i(wen), .payload_i(payload),
        .e_valid_o(e_valid2), .e_ready_i(e_ready),
        .rd_o(rd_o2), .wenReg_o(wen_o2), .payload_o(payload_o2),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .flush_i(flush),
        .busy_o(busy2), .stall_cnt_o(stall2)
    );

    function automatic logic [PW-1:0] rnd_pay();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic bit m_hazard();
        bit h = 0;
        if (use_rs1 && rs1 != 0 && m_busy[rs1]) h = 1;
        if (use_rs2 && rs2 != 0 && m_busy[rs2]) h = 1;
        if (wen && rd != 0 && m_busy[rd]) h = 1;
        return h;
    endfunction

    function automatic bit m_ready();
        return d_valid && !m_hazard() && !flush && (!m_valid || e_ready);
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic void m_reset();
        m_busy = '0; m_valid = 0; m_rd = '0; m_wen = 0; m_pay = '0; m_cnt = 0;
    endfunction

    // Applies the issue rules for one clock given the inputs now held.
    function automatic void m_update();
        bit rdy = m_ready();
        if (d_valid && m_hazard() && !flush) m_cnt++;
        if (flush) begin
            if (m_valid && m_wen && m_rd != 0) m_busy[m_rd] = 0;
            m_valid = 0;
        end
        if (wb_valid && wb_rd != 0) m_busy[wb_rd] = 0;
        if (rdy) begin
            m_valid = 1; m_rd = rd; m_wen = wen; m_pay = payload;
            if (wen && rd != 0) m_busy[rd] = 1;
        end else if (!flush && e_ready) begin
            m_valid = 0;
        end
    endfunction

    task automatic idle();
        d_valid = 0; use_rs1 = 0; use_rs2 = 0; wen = 0;
        rs1 = '0; rs2 = '0; rd = '0; payload = '0;
        e_ready = 0; wb_valid = 0; wb_rd = '0; flush = 0;
    endtask

    task automatic step();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 0;
        m_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [RS_W-1:0] d, input bit w,
                      input logic [RS_W-1:0] s1, input bit u1);
        d_valid = 1; rd = d; wen = w; rs1 = s1; use_rs1 = u1;
        use_rs2 = 0; rs2 = '0; payload = rnd_pay();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests++;
        if ({e_valid, rd_o, wen_o, busy, stall} !== '0 || payload_o !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got ev=%0b rd=%0h busy=%0h cnt=%0h want 0",
                     e_valid, rd_o, busy, stall);
        end
        step();
        op(5'd3, 1, 5'd0, 0);
        e_ready = 0;
        step();
        idle();
        op(5'd4, 1, 5'd3, 1);
        step();
        @(negedge clk);
        n_tests++;
        if (e_valid !== 1'b1 || busy[3] !== 1'b1 || stall !== 16'd1) begin
            n_fail++;
            $display("FAIL pre_reset: got ev=%0b busy=%0h cnt=%0d want 1,bit3,1",
                     e_valid, busy, stall);
        end
        #2 rst_n = 0;
        #1;
        n_tests++;
        if ({e_valid, rd_o, wen_o, busy, stall} !== '0 || payload_o !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got ev=%0b busy=%0h cnt=%0d want 0",
                     e_valid, busy, stall);
        end
        m_reset();
        idle();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_independent();
        do_reset();
        e_ready = 1;
        op(5'd1, 1, 5'd0, 0);
        @(negedge clk);
        n_tests++;
        if (d_ready !== 1'b1) begin
            n_fail++; $display("FAIL indep_rdy1: got %0b want 1", d_ready);
        end
        step();
        op(5'd2, 1, 5'd0, 0);
        @(negedge clk);
        n_tests++;
        if (d_ready !== 1'b1 || e_valid !== 1'b1 || rd_o !== 5'd1) begin
            n_fail++;
            $display("FAIL indep_issue1: got rdy=%0b ev=%0b rd=%0d want 1,1,1",
                     d_ready, e_valid, rd_o);
        end
        step();
        d_valid = 0;
        @(negedge clk);
        n_tests++;
        if (e_valid !== 1'b1 || rd_o !== 5'd2 || busy !== 32'h6) begin
            n_fail++;
            $display("FAIL indep_issue2: got ev=%0b rd=%0d busy=%0h want 1,2,6",
                     e_valid, rd_o, busy);
        end
        step();
    endtask

    task automatic test_raw_stall();
        do_reset();
        e_ready = 1;
        op(5'd5, 1, 5'd0, 0);
        step();
        op(5'd6, 1, 5'd5, 1);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin wb_valid = 1; wb_rd = 5'd5; end
            @(negedge clk);
            n_tests++;
            if (d_ready !== 1'b0) begin
                n_fail++; $display("FAIL raw_stall%0d: got %0b want 0", k, d_ready);
            end
            step();
        end
        wb_valid = 0;
        @(negedge clk);
        n_tests++;
        if (d_ready !== 1'b1) begin
            n_fail++; $display("FAIL raw_release: got %0b want 1", d_ready);
        end
        step();
        idle();
        @(negedge clk);
        n_tests++;
        if (stall !== 16'd3 || stall2 !== 2'd3 || e_valid !== 1'b1 || rd_o !== 5'd6) begin
            n_fail++;
            $display("FAIL raw_count: got cnt=%0d cnt2=%0d ev=%0b rd=%0d want 3,3,1,6",
                     stall, stall2, e_valid, rd_o);
        end
        step();
    endtask

    task automatic test_hold();
        logic [PW-1:0] p1, p2;
        do_reset();
        e_ready = 0;
        op(5'd4, 1, 5'd0, 0);
        p1 = payload;
        step();
        op(5'd8, 1, 5'd0, 0);
        p2 = payload;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++;
            if (e_valid !== 1'b1 || payload_o !== p1 || d_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold%0d: got ev=%0b rdy=%0b pay_ok=%0b want 1,0,1",
                         k, e_valid, d_ready, payload_o === p1);
            end
            step();
        end
        e_ready = 1;
        @(negedge clk);
        n_tests++;
        if (d_ready !== 1'b1) begin
            n_fail++; $display("FAIL hold_rdy: got %0b want 1", d_ready);
        end
        step();
        idle();
        @(negedge clk);
        n_tests++;
        if (e_valid !== 1'b1 || rd_o !== 5'd8 || payload_o !== p2) begin
            n_fail++;
            $display("FAIL hold_replace: got ev=%0b rd=%0d want 1,8", e_valid, rd_o);
        end
        step();
    endtask

    task automatic test_wb_set();
        do_reset();
        e_ready = 1;
        op(5'd7, 1, 5'd0, 0);
        wb_valid = 1; wb_rd = 5'd7;
        @(negedge clk);
        n_tests++;
        if (d_ready !== 1'b1) begin
            n_fail++; $display("FAIL wbset_rdy: got %0b want 1", d_ready);
        end
        step();
        idle();
        @(negedge clk);
        n_tests++;
        if (busy[7] !== 1'b1) begin
            n_fail++; $display("FAIL wbset_busy7: got %0b want 1", busy[7]);
        end
        step();
    endtask

    task automatic test_flush();
        do_reset();
        op(5'd9, 1, 5'd0, 0);
        step();
        op(5'd10, 1, 5'd0, 0);
        flush = 1; e_ready = 1;
        @(negedge clk);
        n_tests++;
        if (d_ready !== 1'b0 || busy[9] !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_rdy: got rdy=%0b b9=%0b want 0,1", d_ready, busy[9]);
        end
        step();
        flush = 0;
        op(5'd11, 1, 5'd0, 0);
        @(negedge clk);
        n_tests++;
        if (e_valid !== 1'b0 || busy[9] !== 1'b0 || busy[10] !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear: got ev=%0b busy=%0h want 0,no 9/10",
                     e_valid, busy);
        end
        step();
        d_valid = 0;
        step();
        flush = 1;
        step();
        idle();
        @(negedge clk);
        n_tests++;
        if (busy[11] !== 1'b1 || e_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_consumed: got b11=%0b ev=%0b want 1,0", busy[11], e_valid);
        end
        step();
    endtask

    task automatic test_x0_and_sat();
        do_reset();
        e_ready = 1;
        op(5'd0, 1, 5'd0, 0);
        step();
        op(5'd0, 1, 5'd0, 1);
        use_rs2 = 1;
        @(negedge clk);
        n_tests++;
        if (busy !== '0 || d_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL x0: got busy=%0h rdy=%0b want 0,1", busy, d_ready);
        end
        step();
        op(5'd12, 1, 5'd0, 0);
        step();
        op(5'd13, 1, 5'd12, 1);
        for (int k = 0; k < 5; k++) step();
        idle();
        @(negedge clk);
        n_tests++;
        if (stall !== 16'd5 || stall2 !== 2'd3) begin
            n_fail++;
            $display("FAIL saturate: got cnt=%0d cnt2=%0d want 5,3", stall, stall2);
        end
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            d_valid  = ($urandom_range(0, 3) != 0);
            rs1      = RS_W'($urandom_range(0, 7));
            rs2      = RS_W'($urandom_range(0, 7));
            rd       = RS_W'($urandom_range(0, 7));
            use_rs1  = $urandom_range(0, 1) == 1;
            use_rs2  = $urandom_range(0, 1) == 1;
            wen      = $urandom_range(0, 3) != 0;
            payload  = rnd_pay();
            e_ready  = $urandom_range(0, 3) != 0;
            wb_valid = $urandom_range(0, 1) == 1;
            wb_rd    = RS_W'($urandom_range(0, 7));
            flush    = $urandom_range(0, 15) == 0;
            @(negedge clk);
            n_tests++;
            if (d_ready !== m_ready() || e_valid !== m_valid || busy !== m_busy) begin
                n_fail++;
                $display("FAIL rnd_ctl c=%0d: got rdy=%0b ev=%0b busy=%0h want %0b,%0b,%0h",
                         c, d_ready, e_valid, busy, m_ready(), m_valid, m_busy);
            end
            n_tests++;
            if (rd_o !== m_rd || wen_o !== m_wen || payload_o !== m_pay) begin
                n_fail++;
                $display("FAIL rnd_slot c=%0d: got rd=%0d wen=%0b want %0d,%0b",
                         c, rd_o, wen_o, m_rd, m_wen);
            end
            n_tests++;
            if (int'(stall) != sat(m_cnt, 65535) || int'(stall2) != sat(m_cnt, 3)) begin
                n_fail++;
                $display("FAIL rnd_cnt c=%0d: got %0d,%0d want %0d,%0d",
                         c, stall, stall2, sat(m_cnt, 65535), sat(m_cnt, 3));
            end
            step();
        end
        idle();
    endtask

    initial begin
        rst_n = 0;
        idle();
        m_reset();
        test_reset();
        test_independent();
        test_raw_stall();
        test_hold();
        test_wb_set();
        test_flush();
        test_x0_and_sat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
